iter_alu: RTL and testbench

ITER_ALU -- requirements
Module: iter_alu

---
 rtl/iter_alu.sv | 178 +++++++++++++++++
 tb/tb_iter_alu.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// rtl/iter_alu.sv - iterative ALU with latency-1 integer ops; ITER_ALU_MULDIV_EN adds multiply and restoring divide
module iter_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] opr_1,
  input  logic [XLEN-1:0] opr_2,
  input  logic [3:0]      alu_op,
  input  logic            flag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);
  localparam int SHW = $clog2(XLEN);

  logic            w_idle;
  logic            w_accept;
  logic            w_fast;
  logic [XLEN-1:0] w_fast_result;
  logic            w_div_done;
  logic [XLEN-1:0] w_div_result;
  logic [XLEN-1:0] w_base_result;
  logic [SHW-1:0]  w_shamt;

  assign w_shamt  = opr_2[SHW-1:0];
  assign in_ready = w_idle && (!out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // Base integer ops, evaluated straight from the request for the acceptance edge
  always_comb begin
    w_base_result = '0;
    case (alu_op[2:0])
      3'b000: w_base_result = flag ? (opr_1 - opr_2) : (opr_1 + opr_2);
      3'b001: w_base_result = opr_1 << w_shamt;
      3'b010: w_base_result = {{(XLEN-1){1'b0}}, ($signed(opr_1) < $signed(opr_2))};
      3'b011: w_base_result = {{(XLEN-1){1'b0}}, (opr_1 < opr_2)};
      3'b100: w_base_result = opr_1 ^ opr_2;
      3'b101: begin
        if (flag) w_base_result = $unsigned($signed(opr_1) >>> w_shamt);
        else      w_base_result = opr_1 >> w_shamt;
      end
      3'b110: w_base_result = opr_1 | opr_2;
      default: w_base_result = opr_1 & opr_2;
    endcase
  end

`ifdef ITER_ALU_MULDIV_EN
  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX} state_t;
  state_t r_state, w_state_nxt;

  logic [SHW-1:0]    r_count;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_dvsr;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_is_rem;

  logic              w_a_sgn;
  logic              w_b_sgn;
  logic [2*XLEN-1:0] w_prod;
  logic              w_is_div;
  logic              w_div_sgn;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic [XLEN-1:0]   w_mag_1;
  logic [XLEN-1:0]   w_mag_2;
  logic [XLEN:0]     w_shifted;
  logic [XLEN:0]     w_trial;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_md_result;

  // One shared multiplier: the operand extension picks signed or unsigned interpretation
  assign w_a_sgn = (alu_op[1:0] != 2'b11) && opr_1[XLEN-1];
  assign w_b_sgn = (alu_op[1:0] == 2'b01) && opr_2[XLEN-1];
  assign w_prod  = {{XLEN{w_a_sgn}}, opr_1} * {{XLEN{w_b_sgn}}, opr_2};

  assign w_is_div   = alu_op[3] && alu_op[2];
  assign w_div_sgn  = !alu_op[0];
  assign w_div_zero = (opr_2 == '0);
  assign w_div_ovf  = w_div_sgn && (opr_1 == {1'b1, {(XLEN-1){1'b0}}}) && (opr_2 == '1);
  assign w_fast     = !w_is_div || w_div_zero || w_div_ovf;
  assign w_mag_1    = (w_div_sgn && opr_1[XLEN-1]) ? -opr_1 : opr_1;
  assign w_mag_2    = (w_div_sgn && opr_2[XLEN-1]) ? -opr_2 : opr_2;

  // Latency-1 results for multiplies and the two divide corner cases
  always_comb begin
    w_md_result = '0;
    case (alu_op[2:0])
      3'b000:                 w_md_result = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_md_result = w_prod[2*XLEN-1:XLEN];
      default: begin
        if (w_div_zero)     w_md_result = alu_op[1] ? opr_1 : '1;
        else if (w_div_ovf) w_md_result = alu_op[1] ? '0 : opr_1;
      end
    endcase
  end

  assign w_fast_result = alu_op[3] ? w_md_result : w_base_result;

  // Restoring step: shift the next dividend bit in, keep the difference if it did not go negative
  assign w_shifted    = {r_rem, r_quo[XLEN-1]};
  assign w_trial      = w_shifted - {1'b0, r_dvsr};
  assign w_quo_fix    = r_neg_q ? -r_quo : r_quo;
  assign w_rem_fix    = r_neg_r ? -r_rem : r_rem;
  assign w_div_result = r_is_rem ? w_rem_fix : w_quo_fix;
  assign w_idle       = (r_state == S_IDLE);
  assign w_div_done   = (r_state == S_FIX);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: long divides run XLEN steps then one sign-fix cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && !w_fast) w_state_nxt = S_DIV;
      S_DIV:   if (r_count == SHW'(XLEN-1)) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Divider operand capture on acceptance, then one quotient bit per DIV cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count  <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvsr   <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_rem <= 1'b0;
    end else if (w_accept && !w_fast) begin
      r_count  <= '0;
      r_quo    <= w_mag_1;
      r_rem    <= '0;
      r_dvsr   <= w_mag_2;
      r_neg_q  <= w_div_sgn && (opr_1[XLEN-1] ^ opr_2[XLEN-1]);
      r_neg_r  <= w_div_sgn && opr_1[XLEN-1];
      r_is_rem <= alu_op[1];
    end else if (r_state == S_DIV) begin
      r_quo   <= {r_quo[XLEN-2:0], !w_trial[XLEN]};
      r_rem   <= w_trial[XLEN] ? w_shifted[XLEN-1:0] : w_trial[XLEN-1:0];
      r_count <= r_count + SHW'(1);
    end
  end
`else
  assign w_idle        = 1'b1;
  assign w_div_done    = 1'b0;
  assign w_div_result  = '0;
  assign w_fast        = 1'b1;
  assign w_fast_result = alu_op[3] ? '0 : w_base_result;
`endif

  // Output register: load on latency-1 accept or divide completion, hold until consumed
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid <= 1'b0;
      result    <= '0;
    end else if (w_accept && w_fast) begin
      out_valid <= 1'b1;
      result    <= w_fast_result;
    end else if (w_div_done) begin
      out_valid <= 1'b1;
      result    <= w_div_result;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_iter_alu.sv
// tb/tb_iter_alu.sv - randomized self-checking bench for iter_alu against a behavioural model
`timescale 1ns/1ps
module tb_iter_alu;
  localparam int XLEN = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;
`ifdef ITER_ALU_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] opr_1 = '0;
  logic [31:0] opr_2 = '0;
  logic [3:0]  alu_op = '0;
  logic        flag = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] pend_exp = '0;
  bit          pend = 1'b0;

  iter_alu #(.XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid(in_valid), .in_ready(in_ready),
    .opr_1(opr_1), .opr_2(opr_2), .alu_op(alu_op), .flag(flag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural meaning of each op
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic fl,
                                          input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    int              sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    sh = int'(b % 32);
    if (!MULDIV && op >= 4'd8) return 32'd0;
    case (op)
      4'd0:  return fl ? 32'(ua - ub) : 32'(ua + ub);
      4'd1:  return 32'(ua << sh);
      4'd2:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd3:  return (ua < ub) ? 32'd1 : 32'd0;
      4'd4:  return a ^ b;
      4'd5:  return fl ? 32'(sa >>> sh) : 32'(ua >> sh);
      4'd6:  return a | b;
      4'd7:  return a & b;
      4'd8:  return 32'(sa * sb);
      4'd9:  return 32'((sa * sb) >>> 32);
      4'd10: return 32'((sa * longint'(ua)) >>> 32);
      4'd11: return 32'((ua * ub) >> 32);
      4'd12: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MINV && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      4'd13: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      4'd14: begin
        if (b == 0) return a;
        if (a == MINV && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : 32'(ua % ub);
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (MULDIV && op >= 4'd12 && b != 0 && !(op[0] == 1'b0 && a == MINV && b == 32'hFFFF_FFFF))
      return XLEN + 2;
    return 1;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return MINV;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Single request: wait for its result with out_ready low, poking in_valid while busy, then hold
  task automatic run_op(input string tag, input logic [3:0] op, input logic fl,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input int hold);
    int n;
    bit got;
    @(negedge clk_i);
    alu_op = op; flag = fl; opr_1 = a; opr_2 = b; in_valid = 1'b1; out_ready = 1'b1;
    #1 check_eq({tag, "_accept_rdy"}, in_ready, 1);
    @(posedge clk_i);
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk_i);
      n++;
      out_ready = 1'b0;
      in_valid  = 1'($urandom_range(0, 1));
      alu_op    = 4'($urandom_range(0, 7));
      opr_1     = $urandom;
      opr_2     = $urandom;
      #1;
      if (out_valid) got = 1'b1;
      check_eq({tag, "_busy_rdy"}, in_ready, 0);
    end
    in_valid = 1'b0;
    check_eq({tag, "_latency"}, n, exp_lat);
    check_eq({tag, "_result"}, result, exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk_i);
      #1;
      check_eq({tag, "_hold_valid"}, out_valid, 1);
      check_eq({tag, "_hold_result"}, result, exp);
      check_eq({tag, "_hold_rdy"}, in_ready, 0);
    end
  endtask

  // Back-to-back issue with out_ready high; checks the previous request's result each cycle
  task automatic issue(input logic [3:0] op, input logic fl, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    @(negedge clk_i);
    alu_op = op; flag = fl; opr_1 = a; opr_2 = b; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    if (pend) begin
      check_eq("b2b_valid", out_valid, 1);
      check_eq("b2b_result", result, pend_exp);
    end
    check_eq("b2b_rdy", in_ready, 1);
    pend_exp = exp;
    pend = 1'b1;
  endtask

  task automatic drain();
    @(negedge clk_i);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    if (pend) begin
      check_eq("drain_valid", out_valid, 1);
      check_eq("drain_result", result, pend_exp);
    end
    pend = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic        fl;
    logic [31:0] a;
    logic [31:0] b;
    int          seen;

    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_rdy", in_ready, 1);

    // Accept on the first edge after release
    @(negedge clk_i);
    rst_i = 1'b0;
    alu_op = 4'd0; flag = 1'b0; opr_1 = 32'd1; opr_2 = 32'd1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check_eq("first_valid", out_valid, 1);
    check_eq("first_result", result, 2);

    issue(4'd0, 1'b0, 32'd5, 32'd7, 32'h0000_000C);
    issue(4'd0, 1'b1, 32'd5, 32'd7, 32'hFFFF_FFFE);
    for (int i = 0; i < 30; i++) begin
      op = MULDIV ? 4'($urandom_range(0, 11)) : 4'($urandom_range(0, 15));
      fl = 1'($urandom_range(0, 1));
      a  = rnd_opnd();
      b  = rnd_opnd();
      issue(op, fl, a, b, ref_alu(op, fl, a, b));
    end
    drain();

    run_op("sra", 4'd5, 1'b1, MINV, 32'h24, 32'hF800_0000, 1, 0);
    run_op("srl", 4'd5, 1'b0, MINV, 32'h24, 32'h0800_0000, 1, 0);
`ifdef ITER_ALU_MULDIV_EN
    run_op("div_m7_2",  4'd12, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
    run_op("rem_m7_2",  4'd14, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
    run_op("divu_zero", 4'd13, 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op("div_ovf",   4'd12, 1'b0, MINV, 32'hFFFF_FFFF, MINV, 1, 0);
    run_op("rem_ovf",   4'd14, 1'b0, MINV, 32'hFFFF_FFFF, 32'd0, 1, 0);
    run_op("mulhu",     4'd11, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 3);
    run_op("mulh",      4'd9,  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1, 3);
`else
    run_op("div_off",   4'd12, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'd0, 1, 0);
    run_op("divu_off",  4'd13, 1'b0, 32'h1234_5678, 32'd0, 32'd0, 1, 0);
    run_op("mulhu_off", 4'd11, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1, 3);
    run_op("mul_off",   4'd8,  1'b0, 32'd3, 32'd5, 32'd0, 1, 3);
`endif

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      fl = 1'($urandom_range(0, 1));
      a  = rnd_opnd();
      b  = rnd_opnd();
      run_op("rand", op, fl, a, b, ref_alu(op, fl, a, b), ref_lat(op, a, b), int'($urandom_range(0, 2)));
    end

    // Asynchronous reset in the middle of work
    run_op("pre_rst", 4'd0, 1'b0, 32'd3, 32'd4, 32'd7, 1, 0);
`ifdef ITER_ALU_MULDIV_EN
    @(negedge clk_i);
    alu_op = 4'd12; flag = 1'b0; opr_1 = 32'hFFFF_FFF9; opr_2 = 32'd2; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (9) @(negedge clk_i);
`else
    @(negedge clk_i);
    out_ready = 1'b0;
`endif
    #1 check_eq("pre_arst_result", result, 7);
    rst_i = 1'b1;
    #1;
    check_eq("arst_valid", out_valid, 0);
    check_eq("arst_result", result, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk_i);
      #1;
      if (out_valid) seen++;
    end
    check_eq("abort_no_result", seen, 0);
    run_op("post_rst_add", 4'd0, 1'b0, 32'd1, 32'd1, 32'd2, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
